// File: rtl/amp_chan_scheduler.sv
// Round-robin scheduler sharing one fixed-latency I/Q amplitude datapath among N_CH channels.
// Each issue is tagged with its channel, and each returned amplitude is matched back to that channel.
module amp_chan_scheduler #(
  parameter int N_CH = 4,
  parameter int DW   = 33,
  parameter int AW   = 24,
  parameter int LAT  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic [N_CH*DW-1:0] ch_i,
  input  logic [N_CH*DW-1:0] ch_q,
  output logic [DW-1:0]     dp_i,
  output logic [DW-1:0]     dp_q,
  output logic              dp_valid,
  input  logic [AW-1:0]     dp_amp,
  input  logic              dp_amp_valid,
  output logic [AW-1:0]     amp_data,
  output logic [2:0]        amp_ch,
  output logic              amp_valid,
  output logic [N_CH-1:0]   overrun,
  output logic              lat_err
);

  // ch_valid, dp_valid, dp_amp_valid and amp_valid are one-cycle strobes with no back-pressure:
  // the receiver must take the data in the same cycle that its valid is high.

  localparam int BW = $clog2(LAT + 1);

  logic [N_CH-1:0] pend;
  logic [DW-1:0]   hold_i [N_CH];
  logic [DW-1:0]   hold_q [N_CH];
  logic [2:0]      ptr;
  logic [2:0]      dp_ch;
  logic            tag_v  [LAT];
  logic [2:0]      tag_ch [LAT];
  logic [BW-1:0]   blank_cnt;

  logic            gnt_found;
  logic [2:0]      gnt_ch;
  logic [N_CH-1:0] issue;
  int              gnt_dist;
  int              cand_dist;

  logic            tag_out_v;
  logic            blank;
  logic            stray_ok;

  // Grant the pending channel with the smallest wrapped distance from ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    gnt_dist  = N_CH;
    cand_dist = 0;
    issue     = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand_dist = k - int'(ptr);
      if (cand_dist < 0) cand_dist = cand_dist + N_CH;
      if (pend[k] && (cand_dist < gnt_dist)) begin
        gnt_dist  = cand_dist;
        gnt_ch    = 3'(k);
        gnt_found = 1'b1;
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      issue[k] = gnt_found && (gnt_ch == 3'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      ptr      <= '0;
      dp_valid <= 1'b0;
      dp_ch    <= '0;
      dp_i     <= '0;
      dp_q     <= '0;
      overrun  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        hold_i[k] <= '0;
        hold_q[k] <= '0;
      end
    end else begin
      dp_valid <= gnt_found;
      if (gnt_found) begin
        dp_ch <= gnt_ch;
        ptr   <= (gnt_ch == 3'(N_CH - 1)) ? 3'd0 : gnt_ch + 3'd1;
      end
      for (int k = 0; k < N_CH; k++) begin
        // The issue reads the old pair while a same-cycle capture replaces it.
        if (issue[k]) begin
          dp_i <= hold_i[k];
          dp_q <= hold_q[k];
        end
        if (ch_valid[k]) begin
          hold_i[k] <= ch_i[k*DW +: DW];
          hold_q[k] <= ch_q[k*DW +: DW];
          pend[k]   <= 1'b1;
          if (pend[k] && !issue[k]) overrun[k] <= 1'b1;
        end else if (issue[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  assign tag_out_v = tag_v[LAT-1];
  assign blank     = (blank_cnt != '0);
  assign stray_ok  = blank && dp_amp_valid && !tag_out_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LAT; j++) begin
        tag_v[j]  <= 1'b0;
        tag_ch[j] <= '0;
      end
      blank_cnt <= BW'(LAT);
      amp_valid <= 1'b0;
      amp_data  <= '0;
      amp_ch    <= '0;
      lat_err   <= 1'b0;
    end else begin
      tag_v[0]  <= dp_valid;
      tag_ch[0] <= dp_ch;
      for (int j = 1; j < LAT; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_ch[j] <= tag_ch[j-1];
      end
      if (blank) blank_cnt <= blank_cnt - 1'b1;

      amp_valid <= tag_out_v && dp_amp_valid;
      if (tag_out_v && dp_amp_valid) begin
        amp_data <= dp_amp;
        amp_ch   <= tag_ch[LAT-1];
      end
      // Returns left over from before a reset arrive untagged and are dropped quietly.
      if ((tag_out_v != dp_amp_valid) && !stray_ok) lat_err <= 1'b1;
    end
  end

endmodule
